// File: rtl/sm_dot_acc_if.sv
// rtl/sm_dot_acc_if.sv - start/term/result signal bundle for the dot-product accumulator
interface sm_dot_acc_if #(
   parameter int PROD_W = 32,
   parameter int ACC_W  = 40,
   parameter int CNT_W  = 8
);
   logic              acc_start;
   logic [CNT_W-1:0]  len;
   logic              sm_ready;
   logic [PROD_W-1:0] sm_product;
   logic              acc_ack;
   logic [ACC_W-1:0]  acc_out;
   logic              acc_valid;
   logic              overflow;
   logic              busy;
   logic [CNT_W-1:0]  count;

   modport master (
      output acc_start, len, sm_ready, sm_product, acc_ack,
      input  acc_out, acc_valid, overflow, busy, count
   );

   modport slave (
      input  acc_start, len, sm_ready, sm_product, acc_ack,
      output acc_out, acc_valid, overflow, busy, count
   );
endinterface

// File: rtl/sm_dot_acc.sv
// rtl/sm_dot_acc.sv - sums a programmed number of multiplier products with saturation
module sm_dot_acc #(
   parameter int PROD_W = 32,
   parameter int ACC_W  = 40,
   parameter int CNT_W  = 8
) (
   input  logic         clk,
   input  logic         reset,
   sm_dot_acc_if.slave  bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t            state;
   logic [ACC_W-1:0]  acc_q;
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  len_q;
   logic              valid_q;
   logic              ovf_q;
   logic              busy_q;
   logic              ready_q;

   logic              term;
   logic              start_ok;
   logic [ACC_W:0]    sum;
   logic [CNT_W-1:0]  count_nx;

   // A term is a rising ready; ready_q resets high so a level already up at release is skipped.
   assign term     = bus.sm_ready & ~ready_q;
   assign start_ok = bus.acc_start & (state != HOLD);
   assign sum      = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.sm_product};
   assign count_nx = count_q + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         acc_q   <= '0;
         count_q <= '0;
         len_q   <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         ready_q <= bus.sm_ready;
         if (start_ok) begin
            // Restart from ACCUM beats any coincident term; that product is dropped.
            len_q   <= bus.len;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            if (bus.len == '0) begin
               state   <= HOLD;
               valid_q <= 1'b1;
               busy_q  <= 1'b0;
            end else begin
               state   <= ACCUM;
               valid_q <= 1'b0;
               busy_q  <= 1'b1;
            end
         end else begin
            case (state)
               ACCUM: begin
                  if (term) begin
                     if (sum[ACC_W] || ovf_q) begin
                        acc_q <= {ACC_W{1'b1}};
                        ovf_q <= 1'b1;
                     end else begin
                        acc_q <= sum[ACC_W-1:0];
                     end
                     count_q <= count_nx;
                     if (count_nx == len_q) begin
                        state   <= HOLD;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                     end
                  end
               end
               HOLD: begin
                  if (bus.acc_ack) begin
                     state   <= IDLE;
                     valid_q <= 1'b0;
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

   assign bus.acc_out   = acc_q;
   assign bus.acc_valid = valid_q;
   assign bus.overflow  = ovf_q;
   assign bus.busy      = busy_q;
   assign bus.count     = count_q;
endmodule

// File: tb/tb_sm_dot_acc.sv
// tb/tb_sm_dot_acc.sv - scoreboard bench for sm_dot_acc at 40-bit and 34-bit accumulator widths
module tb_sm_dot_acc;
   logic        clk = 1'b0;
   logic        reset;
   logic        acc_start;
   logic [7:0]  len;
   logic        sm_ready;
   logic [31:0] sm_product;
   logic        acc_ack;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [39:0] acc;
      logic [7:0]  cnt;
      logic        ovf;
   } res_t;

   res_t q40[$];
   res_t q34[$];

   sm_dot_acc_if #(.PROD_W(32), .ACC_W(40), .CNT_W(8)) if40 ();
   sm_dot_acc_if #(.PROD_W(32), .ACC_W(34), .CNT_W(8)) if34 ();

   assign if40.acc_start  = acc_start;
   assign if40.len        = len;
   assign if40.sm_ready   = sm_ready;
   assign if40.sm_product = sm_product;
   assign if40.acc_ack    = acc_ack;
   assign if34.acc_start  = acc_start;
   assign if34.len        = len;
   assign if34.sm_ready   = sm_ready;
   assign if34.sm_product = sm_product;
   assign if34.acc_ack    = acc_ack;

   sm_dot_acc #(.PROD_W(32), .ACC_W(40), .CNT_W(8)) dut40 (.clk(clk), .reset(reset), .bus(if40));
   sm_dot_acc #(.PROD_W(32), .ACC_W(34), .CNT_W(8)) dut34 (.clk(clk), .reset(reset), .bus(if34));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [39:0] a40, input logic [39:0] a34, input logic [7:0] c,
                       input logic o40, input logic o34);
      q40.push_back('{acc: a40, cnt: c, ovf: o40});
      q34.push_back('{acc: a34, cnt: c, ovf: o34});
   endtask

   task automatic start(input logic [7:0] l);
      acc_start = 1'b1;
      len       = l;
      tick();
      acc_start = 1'b0;
   endtask

   task automatic term(input logic [31:0] p);
      sm_product = p;
      sm_ready   = 1'b1;
      tick();
      sm_ready   = 1'b0;
      tick();
   endtask

   task automatic ack;
      acc_ack = 1'b1;
      tick();
      acc_ack = 1'b0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_acc40"}, if40.acc_out, 0);
      chk({tag, "_valid40"}, if40.acc_valid, 0);
      chk({tag, "_ovf40"}, if40.overflow, 0);
      chk({tag, "_busy40"}, if40.busy, 0);
      chk({tag, "_cnt40"}, if40.count, 0);
      chk({tag, "_acc34"}, if34.acc_out, 0);
      chk({tag, "_valid34"}, if34.acc_valid, 0);
   endtask

   // Scoreboard monitors: compare a queued result each time acc_valid rises.
   logic pv40 = 1'b0;
   logic pv34 = 1'b0;
   always @(negedge clk) begin : mon40
      res_t e;
      if (if40.acc_valid && !pv40) begin
         if (q40.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mon40_unexpected actual=%0h expected=none", if40.acc_out);
         end else begin
            e = q40.pop_front();
            chk("mon40_acc", if40.acc_out, e.acc);
            chk("mon40_cnt", if40.count, e.cnt);
            chk("mon40_ovf", if40.overflow, e.ovf);
         end
      end
      pv40 = if40.acc_valid;
   end

   always @(negedge clk) begin : mon34
      res_t e;
      if (if34.acc_valid && !pv34) begin
         if (q34.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mon34_unexpected actual=%0h expected=none", if34.acc_out);
         end else begin
            e = q34.pop_front();
            chk("mon34_acc", {30'd0, if34.acc_out}, e.acc);
            chk("mon34_cnt", if34.count, e.cnt);
            chk("mon34_ovf", if34.overflow, e.ovf);
         end
      end
      pv34 = if34.acc_valid;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; acc_start = 1'b0; len = '0;
      sm_ready = 1'b1; sm_product = '0; acc_ack = 1'b0;
      tick(); tick();
      chk_reset("rst");
      reset = 1'b1;
      tick(); tick();

      // Ready high across reset release must not count; then level vs edge.
      push(40'd12, 40'd12, 8'd2, 1'b0, 1'b0);
      start(8'd2);
      chk("lvl_busy", if40.busy, 1);
      tick(); tick();
      chk("lvl_rst_high_cnt", if40.count, 0);
      sm_ready = 1'b0;
      tick();
      sm_product = 32'd5;
      sm_ready   = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      chk("lvl_hold_cnt", if40.count, 1);
      chk("lvl_hold_acc", if40.acc_out, 5);
      sm_ready = 1'b0;
      tick();
      term(32'd7);
      ack();

      // Basic sum.
      push(40'hFF_FF00_07 << 0 | 40'h00_FFFF_0007, 40'h00_FFFF_0007, 8'd3, 1'b0, 1'b0);
      start(8'd3);
      chk("basic_start_cnt", if40.count, 0);
      chk("basic_start_acc", if40.acc_out, 0);
      term(32'd6);
      chk("basic_t1_acc", if40.acc_out, 6);
      term(32'h0001_0000);
      sm_product = 32'hFFFE_0001;
      sm_ready   = 1'b1;
      tick();
      chk("basic_done_valid", if40.acc_valid, 1);
      chk("basic_done_busy", if40.busy, 0);
      sm_ready = 1'b0;
      tick();
      ack();
      chk("basic_ack_valid", if40.acc_valid, 0);
      chk("basic_idle_acc", if40.acc_out, 40'h00_FFFF_0007);

      // Zero length; start is ignored in HOLD, even alongside ack.
      push(40'd0, 40'd0, 8'd0, 1'b0, 1'b0);
      start(8'd0);
      chk("zero_valid", if40.acc_valid, 1);
      chk("zero_busy", if40.busy, 0);
      start(8'd3);
      chk("zero_hold_valid", if40.acc_valid, 1);
      acc_start = 1'b1; acc_ack = 1'b1; len = 8'd3;
      tick();
      acc_start = 1'b0; acc_ack = 1'b0;
      chk("zero_ack_valid", if40.acc_valid, 0);
      chk("zero_ack_busy", if40.busy, 0);

      // Overflow at 34 bits; the 40-bit instance does not overflow.
      push(40'h4_FFF6_0005, 40'h3_FFFF_FFFF, 8'd5, 1'b0, 1'b1);
      start(8'd5);
      for (int i = 0; i < 4; i++) term(32'hFFFE_0001);
      chk("ovf_t4_acc34", if34.acc_out, 34'h3_FFF8_0004);
      chk("ovf_t4_ovf34", if34.overflow, 0);
      term(32'hFFFE_0001);
      chk("ovf_t5_ovf34", if34.overflow, 1);
      ack();

      // Restart collision: restart wins over a coincident term.
      push(40'd4, 40'd4, 8'd1, 1'b0, 1'b0);
      start(8'd3);
      term(32'd2);
      chk("rs_pre_cnt", if40.count, 1);
      acc_start = 1'b1; len = 8'd1; sm_ready = 1'b1; sm_product = 32'd9;
      tick();
      acc_start = 1'b0; sm_ready = 1'b0;
      chk("rs_cnt", if40.count, 0);
      chk("rs_acc", if40.acc_out, 0);
      chk("rs_busy", if40.busy, 1);
      tick();
      term(32'd4);
      ack();

      // Reset during ACCUM and during HOLD.
      start(8'd3);
      term(32'd5);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk_reset("rst_accum");
      push(40'd3, 40'd3, 8'd1, 1'b0, 1'b0);
      start(8'd1);
      term(32'd3);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk_reset("rst_hold");
      push(40'd8, 40'd8, 8'd1, 1'b0, 1'b0);
      start(8'd1);
      term(32'd8);
      ack();
      tick(); tick();

      chk("q40_empty", q40.size(), 0);
      chk("q34_empty", q34.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
